// File: rtl/pe_bypass_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_bypass_ctrl_if : IF-stage decode fields in, bypass flags/selects out
// Rev 1.0
// ----------------------------------------------------------------------------
interface pe_bypass_ctrl_if #(
  parameter int RF_INDEX_WIDTH = 5
);
  logic                      if_valid;
  logic                      if_stall;
  logic                      if_flush;
  logic [RF_INDEX_WIDTH-1:0] rd_addr_a;
  logic [RF_INDEX_WIDTH-1:0] rd_addr_b;
  logic                      use_a;
  logic                      use_b;
  logic                      wr_en;
  logic [RF_INDEX_WIDTH-1:0] wr_addr;
  logic [1:0]                wr_src;
  logic                      bp_read_a;
  logic                      bp_read_b;
  logic [1:0]                bp_sel_a;
  logic [1:0]                bp_sel_b;
  logic                      hazard_stall;

  modport master (
    output if_valid, if_stall, if_flush,
    output rd_addr_a, rd_addr_b, use_a, use_b,
    output wr_en, wr_addr, wr_src,
    input  bp_read_a, bp_read_b, bp_sel_a, bp_sel_b, hazard_stall
  );

  modport slave (
    input  if_valid, if_stall, if_flush,
    input  rd_addr_a, rd_addr_b, use_a, use_b,
    input  wr_en, wr_addr, wr_src,
    output bp_read_a, bp_read_b, bp_sel_a, bp_sel_b, hazard_stall
  );
endinterface
`default_nettype wire

// File: rtl/pe_bypass_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_bypass_ctrl : tracks the ID-slot destination and drives registered
//                  operand bypass flags/selects plus the load-use stall
// Rev 1.0
// ----------------------------------------------------------------------------
module pe_bypass_ctrl #(
  parameter int RF_INDEX_WIDTH = 5,
  parameter int BP_MIN_ADDR    = 2,
  parameter int SHADOW_ADDR    = 31,
  parameter bit LSU_BYPASS_EN  = 1'b1
) (
  input  wire                clk,
  input  wire                rst_n,
  pe_bypass_ctrl_if.slave    bus
);

  localparam logic [RF_INDEX_WIDTH-1:0] c_bp_min   = RF_INDEX_WIDTH'(BP_MIN_ADDR);
  localparam logic [RF_INDEX_WIDTH-1:0] c_shadow   = RF_INDEX_WIDTH'(SHADOW_ADDR);
  localparam logic [1:0]                c_src_alu  = 2'b00;
  localparam logic [1:0]                c_src_lsu  = 2'b10;
  localparam logic [1:0]                c_src_shd  = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_LDSTALL = 1'b1
  } state_t;

  state_t                    r_state,      w_state_nxt;
  logic                      r_id_valid,   w_id_valid_nxt;
  logic [RF_INDEX_WIDTH-1:0] r_id_waddr,   w_id_waddr_nxt;
  logic [1:0]                r_id_src,     w_id_src_nxt;
  logic                      r_bp_read_a,  w_bp_read_a_nxt;
  logic                      r_bp_read_b,  w_bp_read_b_nxt;
  logic [1:0]                r_bp_sel_a,   w_bp_sel_a_nxt;
  logic [1:0]                r_bp_sel_b,   w_bp_sel_b_nxt;

  logic                      w_match_a;
  logic                      w_match_b;
  logic [1:0]                w_eff_src;
  logic                      w_load_use;
  logic                      w_trk_valid;

  // Compare the IF read ports against the producer currently in ID.
  always_comb begin
    w_match_a  = bus.if_valid & bus.use_a & r_id_valid &
                 (bus.rd_addr_a == r_id_waddr) & (bus.rd_addr_a >= c_bp_min);
    w_match_b  = bus.if_valid & bus.use_b & r_id_valid &
                 (bus.rd_addr_b == r_id_waddr) & (bus.rd_addr_b >= c_bp_min);
    w_eff_src  = (r_id_waddr == c_shadow) ? c_src_shd : r_id_src;
    w_load_use = !LSU_BYPASS_EN & (r_state == ST_RUN) &
                 (w_eff_src == c_src_lsu) & (w_match_a | w_match_b);
    w_trk_valid = bus.if_valid & bus.wr_en & (bus.wr_addr >= c_bp_min);
  end

  // Stall freezes everything; flush outranks stall and empties the pipe.
  always_comb begin
    w_state_nxt     = r_state;
    w_id_valid_nxt  = r_id_valid;
    w_id_waddr_nxt  = r_id_waddr;
    w_id_src_nxt    = r_id_src;
    w_bp_read_a_nxt = r_bp_read_a;
    w_bp_read_b_nxt = r_bp_read_b;
    w_bp_sel_a_nxt  = r_bp_sel_a;
    w_bp_sel_b_nxt  = r_bp_sel_b;

    if (bus.if_flush) begin
      w_state_nxt     = ST_RUN;
      w_id_valid_nxt  = 1'b0;
      w_bp_read_a_nxt = 1'b0;
      w_bp_read_b_nxt = 1'b0;
      w_bp_sel_a_nxt  = c_src_alu;
      w_bp_sel_b_nxt  = c_src_alu;
    end else if (!bus.if_stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            // Bubble into ID; the IF instruction is held and reissued next cycle.
            w_state_nxt     = ST_LDSTALL;
            w_id_valid_nxt  = 1'b0;
            w_bp_read_a_nxt = 1'b0;
            w_bp_read_b_nxt = 1'b0;
            w_bp_sel_a_nxt  = c_src_alu;
            w_bp_sel_b_nxt  = c_src_alu;
          end else begin
            w_bp_read_a_nxt = w_match_a;
            w_bp_read_b_nxt = w_match_b;
            w_bp_sel_a_nxt  = w_match_a ? w_eff_src : c_src_alu;
            w_bp_sel_b_nxt  = w_match_b ? w_eff_src : c_src_alu;
            w_id_valid_nxt  = w_trk_valid;
            w_id_waddr_nxt  = bus.wr_addr;
            w_id_src_nxt    = bus.wr_src;
          end
        end
        ST_LDSTALL: begin
          // Load result reaches the held instruction through the RF write port.
          w_state_nxt     = ST_RUN;
          w_bp_read_a_nxt = 1'b0;
          w_bp_read_b_nxt = 1'b0;
          w_bp_sel_a_nxt  = c_src_alu;
          w_bp_sel_b_nxt  = c_src_alu;
          w_id_valid_nxt  = w_trk_valid;
          w_id_waddr_nxt  = bus.wr_addr;
          w_id_src_nxt    = bus.wr_src;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_id_valid  <= 1'b0;
      r_id_waddr  <= '0;
      r_id_src    <= c_src_alu;
      r_bp_read_a <= 1'b0;
      r_bp_read_b <= 1'b0;
      r_bp_sel_a  <= c_src_alu;
      r_bp_sel_b  <= c_src_alu;
    end else begin
      r_state     <= w_state_nxt;
      r_id_valid  <= w_id_valid_nxt;
      r_id_waddr  <= w_id_waddr_nxt;
      r_id_src    <= w_id_src_nxt;
      r_bp_read_a <= w_bp_read_a_nxt;
      r_bp_read_b <= w_bp_read_b_nxt;
      r_bp_sel_a  <= w_bp_sel_a_nxt;
      r_bp_sel_b  <= w_bp_sel_b_nxt;
    end
  end

  assign bus.bp_read_a    = r_bp_read_a;
  assign bus.bp_read_b    = r_bp_read_b;
  assign bus.bp_sel_a     = r_bp_sel_a;
  assign bus.bp_sel_b     = r_bp_sel_b;
  assign bus.hazard_stall = w_load_use & !bus.if_flush;

endmodule
`default_nettype wire

// File: tb/tb_pe_bypass_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pe_bypass_ctrl : directed vectors with a queued scoreboard (LSU bypass off)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pe_bypass_ctrl;

  logic clk;
  logic rst_n;

  pe_bypass_ctrl_if #(.RF_INDEX_WIDTH(5)) bif ();

  pe_bypass_ctrl #(
    .RF_INDEX_WIDTH (5),
    .BP_MIN_ADDR    (2),
    .SHADOW_ADDR    (31),
    .LSU_BYPASS_EN  (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each record holds the stall expected in the vector's own cycle and the
  // registered outputs expected to be visible during that cycle.
  typedef struct {
    int         idx;
    logic       hz;
    logic       bra;
    logic       brb;
    logic [1:0] sa;
    logic [1:0] sb;
  } exp_t;

  exp_t exp_q[$];
  int   vec_idx   = 0;
  bit   stim_done = 1'b0;

  task automatic apply(
    input logic       r,  input logic v,  input logic st, input logic fl,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic       ua, input logic ub, input logic we,
    input logic [4:0] wa, input logic [1:0] ws,
    input logic       hz, input logic bra, input logic brb,
    input logic [1:0] sa, input logic [1:0] sb
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = r;
    bif.if_valid  = v;
    bif.if_stall  = st;
    bif.if_flush  = fl;
    bif.rd_addr_a = ra;
    bif.rd_addr_b = rb;
    bif.use_a     = ua;
    bif.use_b     = ub;
    bif.wr_en     = we;
    bif.wr_addr   = wa;
    bif.wr_src    = ws;
    e.idx = vec_idx;
    e.hz  = hz;
    e.bra = bra;
    e.brb = brb;
    e.sa  = sa;
    e.sb  = sb;
    exp_q.push_back(e);
    vec_idx = vec_idx + 1;
  endtask

  // Source codes: ALU=0 MUL=1 LSU=2 SHADOW=3
  initial begin
    rst_n         = 1'b1;
    bif.if_valid  = 1'b0;
    bif.if_stall  = 1'b0;
    bif.if_flush  = 1'b0;
    bif.rd_addr_a = '0;
    bif.rd_addr_b = '0;
    bif.use_a     = 1'b0;
    bif.use_b     = 1'b0;
    bif.wr_en     = 1'b0;
    bif.wr_addr   = '0;
    bif.wr_src    = 2'd0;
    //     r  v  st fl ra  rb  ua ub we wa  ws   hz bra brb sa sb
    apply(0, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0); // reset
    apply(1, 1, 0, 0,  0,  0, 0, 0, 1,  5, 0,   0, 0, 0, 0, 0); // ADD r5
    apply(1, 1, 0, 0,  5,  5, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // read A=r5
    apply(1, 1, 0, 0,  0,  0, 0, 0, 1,  7, 1,   0, 1, 0, 0, 0); // MUL r7
    apply(1, 1, 0, 0,  7,  7, 1, 1, 1,  1, 0,   0, 0, 0, 0, 0); // A=B=r7, write r1
    apply(1, 1, 0, 0,  1,  1, 1, 1, 1, 31, 0,   0, 1, 1, 1, 1); // read r1, write r31
    apply(1, 1, 0, 0, 31,  0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // read r31
    apply(1, 1, 0, 0,  0,  0, 0, 0, 1,  9, 2,   0, 1, 0, 3, 0); // LD r9
    apply(1, 1, 0, 0,  0,  9, 0, 1, 1, 10, 0,   1, 0, 0, 0, 0); // B=r9 load-use
    apply(1, 1, 0, 0,  0,  9, 0, 1, 1, 10, 0,   0, 0, 0, 0, 0); // held reissue
    apply(1, 1, 0, 0, 10,  0, 1, 0, 1, 12, 1,   0, 0, 0, 0, 0); // A=r10, MUL r12
    apply(1, 1, 1, 0,  0, 12, 0, 1, 0,  0, 0,   0, 1, 0, 0, 0); // stall x3
    apply(1, 1, 1, 0,  0, 12, 0, 1, 0,  0, 0,   0, 1, 0, 0, 0);
    apply(1, 1, 1, 0,  0, 12, 0, 1, 0,  0, 0,   0, 1, 0, 0, 0);
    apply(1, 1, 0, 0,  0, 12, 0, 1, 0,  0, 0,   0, 1, 0, 0, 0); // resume B=r12
    apply(1, 1, 0, 0,  0,  0, 0, 0, 1,  4, 0,   0, 0, 1, 0, 1); // ADD r4
    apply(1, 1, 0, 1,  4,  0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // flush
    apply(1, 1, 0, 0,  4,  0, 1, 0, 1,  9, 2,   0, 0, 0, 0, 0); // A=r4 after flush, LD r9
    apply(1, 1, 1, 0,  9,  0, 1, 0, 0,  0, 0,   1, 0, 0, 0, 0); // stalled load-use
    apply(1, 1, 1, 1,  9,  0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // flush over stall
    apply(1, 1, 0, 0,  9,  0, 1, 0, 1,  9, 2,   0, 0, 0, 0, 0); // LD r9
    apply(1, 1, 0, 0,  9,  0, 1, 0, 0,  0, 0,   1, 0, 0, 0, 0); // load-use
    apply(0, 1, 0, 0,  9,  0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // reset in LDSTALL
    apply(1, 1, 0, 0,  0,  0, 0, 0, 1,  9, 2,   0, 0, 0, 0, 0); // LD r9
    apply(1, 1, 0, 0,  9,  0, 1, 0, 0,  0, 0,   1, 0, 0, 0, 0); // load-use from RUN
    apply(1, 1, 0, 0,  9,  0, 1, 0, 0,  0, 0,   0, 0, 0, 0, 0); // held reissue
    apply(1, 0, 0, 0,  0,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0); // idle
    stim_done = 1'b1;
  end

  // Monitor: one record per cycle, sampled on the falling edge.
  initial begin
    int   n_vec;
    int   n_err;
    int   cyc;
    exp_t e;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec = n_vec + 1;
        if (bif.hazard_stall !== e.hz) begin
          n_err = n_err + 1;
          $display("FAIL v%0d hazard_stall: got %b want %b", e.idx, bif.hazard_stall, e.hz);
        end
        if (bif.bp_read_a !== e.bra) begin
          n_err = n_err + 1;
          $display("FAIL v%0d bp_read_a: got %b want %b", e.idx, bif.bp_read_a, e.bra);
        end
        if (bif.bp_read_b !== e.brb) begin
          n_err = n_err + 1;
          $display("FAIL v%0d bp_read_b: got %b want %b", e.idx, bif.bp_read_b, e.brb);
        end
        if (bif.bp_sel_a !== e.sa) begin
          n_err = n_err + 1;
          $display("FAIL v%0d bp_sel_a: got %0d want %0d", e.idx, bif.bp_sel_a, e.sa);
        end
        if (bif.bp_sel_b !== e.sb) begin
          n_err = n_err + 1;
          $display("FAIL v%0d bp_sel_b: got %0d want %0d", e.idx, bif.bp_sel_b, e.sb);
        end
      end else if (stim_done) begin
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      if (cyc > 500) begin
        n_err = n_err + 1;
        $display("FAIL timeout: got %0d cycles want at most 500", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

endmodule
`default_nettype wire
